// File: rtl/hazard_ctrl_pkg.sv
// Shared state encodings and register-address constants for the uDLX pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam int R0_ADDR = 0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment in the same cycle.
// One-cycle update latency, no backpressure.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// uDLX pipeline sequencing: load-use bubbles, redirect squash, data-memory freeze with timeout.
// Stall/flush outputs are combinational from state and inputs; state, counters and error are registered.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 2,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr2,
  input  logic                      id_rd1_used,
  input  logic                      id_rd2_used,
  input  logic                      ex_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr,
  input  logic                      ex_redirect,
  input  logic                      mem_req,
  input  logic                      mem_ack,
  input  logic                      cnt_clr,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_stall,
  output logic                      id_ex_flush,
  output logic                      ex_mem_stall,
  output logic                      mem_error,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_t          r_state, w_state_nxt, w_eff_state;
  logic [FC_W-1:0] r_flush_left, w_flush_left_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            r_resume, w_resume_nxt;
  logic            r_mem_error;
  logic            w_timeout, w_freeze, w_load_use, w_src1_hit, w_src2_hit;
  logic            w_pc_stall, w_if_id_stall, w_if_id_flush;
  logic            w_id_ex_stall, w_id_ex_flush, w_ex_mem_stall, w_flush_inc;

  // In MEM_WAIT the release cycle behaves like the state that was interrupted.
  always_comb begin
    w_timeout   = (r_state == ST_MEM_WAIT) && (r_to_cnt == TO_W'(MEM_TIMEOUT));
    w_freeze    = mem_req && !mem_ack && !w_timeout;
    w_eff_state = r_state;
    if (r_state == ST_MEM_WAIT) begin
      w_eff_state = (r_resume && !w_timeout) ? ST_REDIRECT : ST_RUN;
    end
    w_src1_hit = id_rd1_used && (id_rd_addr1 == ex_wr_addr);
    w_src2_hit = id_rd2_used && (id_rd_addr2 == ex_wr_addr);
    w_load_use = ex_load && (ex_wr_addr != REG_ADDR_WIDTH'(R0_ADDR)) && (w_src1_hit || w_src2_hit);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_flush_left_nxt = r_flush_left;
    w_to_cnt_nxt     = '0;
    w_resume_nxt     = r_resume;
    w_pc_stall       = 1'b0;
    w_if_id_stall    = 1'b0;
    w_if_id_flush    = 1'b0;
    w_id_ex_stall    = 1'b0;
    w_id_ex_flush    = 1'b0;
    w_ex_mem_stall   = 1'b0;
    w_flush_inc      = 1'b0;
    if (w_freeze) begin
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
      w_state_nxt    = ST_MEM_WAIT;
      w_to_cnt_nxt   = r_to_cnt + 1'b1;
      w_resume_nxt   = (w_eff_state == ST_REDIRECT);
    end else begin
      w_state_nxt  = ST_RUN;
      w_resume_nxt = 1'b0;
      if (ex_redirect) begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
        w_flush_inc   = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_state_nxt      = ST_REDIRECT;
          w_flush_left_nxt = FC_W'(FLUSH_CYCLES - 1);
        end
      end else if (w_eff_state == ST_REDIRECT) begin
        // ID holds a wrong-path instruction here, so load-use is not considered.
        w_if_id_flush = 1'b1;
        if (r_flush_left > FC_W'(1)) begin
          w_state_nxt      = ST_REDIRECT;
          w_flush_left_nxt = r_flush_left - 1'b1;
        end else begin
          w_flush_left_nxt = '0;
        end
      end else if (w_load_use) begin
        w_pc_stall    = 1'b1;
        w_if_id_stall = 1'b1;
        w_id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_flush_left <= '0;
      r_to_cnt     <= '0;
      r_resume     <= 1'b0;
      r_mem_error  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_left <= w_flush_left_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_resume     <= w_resume_nxt;
      if (w_timeout) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  assign pc_stall     = w_pc_stall     && !rst;
  assign if_id_stall  = w_if_id_stall  && !rst;
  assign if_id_flush  = w_if_id_flush  && !rst;
  assign id_ex_stall  = w_id_ex_stall  && !rst;
  assign id_ex_flush  = w_id_ex_flush  && !rst;
  assign ex_mem_stall = w_ex_mem_stall && !rst;
  assign mem_error    = r_mem_error;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc && !rst),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule
